// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the memory pins.
// The slave modport is the arbiter's view; master is the environment (requesters and memory).
interface data_mem_arbiter_if #(
   parameter int BYTE_SIZE  = 4,
   parameter int ADDR_WIDTH = 32
);
   localparam int DATA_W = BYTE_SIZE * 8;

   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_W-1:0]     m0_wdata;
   logic [DATA_W-1:0]     m0_rdata;
   logic                  m0_ack;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_W-1:0]     m1_wdata;
   logic [DATA_W-1:0]     m1_rdata;
   logic                  m1_ack;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wd;
   logic [DATA_W-1:0]     mem_rd;
   logic                  busy;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_rdata, m0_ack,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_rdata, m1_ack,
      output mem_we, mem_addr, mem_wd,
      input  mem_rd,
      output busy
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_rdata, m0_ack,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_rdata, m1_ack,
      input  mem_we, mem_addr, mem_wd,
      output mem_rd,
      input  busy
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the load/store
// unit (port 0) and the loader/debug engine (port 1); one access per three cycles.
module data_mem_arbiter #(
   parameter int BYTE_SIZE  = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   data_mem_arbiter_if.slave   bus
);
   localparam int DATA_W = BYTE_SIZE * 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_grant;
   logic                  w_grant_idx;

   logic                  r_winner;
   logic                  r_rr_last;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_W-1:0]     r_mem_wd;
   logic [DATA_W-1:0]     r_m0_rdata;
   logic [DATA_W-1:0]     r_m1_rdata;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_grant_idx  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.m0_req || bus.m1_req) begin
               w_grant      = 1'b1;
               w_grant_idx  = (bus.m0_req && bus.m1_req) ? ~r_rr_last : bus.m1_req;
               w_next_state = S_ACCESS;
            end
         end
         S_ACCESS: w_next_state = S_DONE;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Requester inputs are captured only at grant, so later changes cannot disturb the access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_winner   <= 1'b0;
         r_rr_last  <= 1'b1;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_wd   <= '0;
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_winner   <= w_grant_idx;
            r_rr_last  <= w_grant_idx;
            r_mem_we   <= w_grant_idx ? bus.m1_we    : bus.m0_we;
            r_mem_addr <= w_grant_idx ? bus.m1_addr  : bus.m0_addr;
            r_mem_wd   <= w_grant_idx ? bus.m1_wdata : bus.m0_wdata;
         end
         if (r_state == S_ACCESS) begin
            r_mem_we <= 1'b0;
            if (r_winner) r_m1_rdata <= bus.mem_rd;
            else          r_m0_rdata <= bus.mem_rd;
         end
      end
   end

   assign bus.mem_we   = r_mem_we;
   assign bus.mem_addr = r_mem_addr;
   assign bus.mem_wd   = r_mem_wd;
   assign bus.m0_rdata = r_m0_rdata;
   assign bus.m1_rdata = r_m1_rdata;
   // Ack decodes from state so an asynchronous reset in DONE cuts the pulse at once.
   assign bus.m0_ack   = (r_state == S_DONE) && !r_winner;
   assign bus.m1_ack   = (r_state == S_DONE) &&  r_winner;
   assign bus.busy     = (r_state != S_IDLE);
endmodule
